// File: rtl/eqm_game_ctrl.sv
// Game sequencer: calibration, level select, per-round prep, move generation, play, win/lose.
// Latency: one cycle from an input event to the state change; status outputs are Moore decodes.
// Backpressure: none, events are single-cycle pulses; optional pause (EQM_PAUSE_EN) freezes PREP/PLAY.
module eqm_game_ctrl #(
    parameter int NUM_ROUNDS    = 8,
    parameter int LIVES         = 3,
    parameter int PREP_CYCLES   = 50000000,
    parameter int PLAY_TIMEOUT  = 250000000,
    parameter int CALIB_TIMEOUT = 500000000,
    localparam int SW = $clog2(NUM_ROUNDS + 1),
    localparam int LW = $clog2(LIVES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_game,
    input  logic          ponto_evento,
    input  logic          erro_evento,
    input  logic          sensor_fim_curso,
`ifdef EQM_PAUSE_EN
    input  logic          pause,
    output logic          pausado,
`endif
    output logic          gerar_nova_jogada,
    output logic          conta_nivel,
    output logic          reset_nivel,
    output logic          fade_trigger,
    output logic          trava_servo,
    output logic          calib_start,
    output logic          game_over,
    output logic          venceu,
    output logic          calib_fault,
    output logic [SW-1:0] score,
    output logic [LW-1:0] lives,
    output logic [2:0]    db_estado
);

    typedef enum logic [2:0] {
        S_CALIB      = 3'd0,
        S_SEL        = 3'd1,
        S_PREP       = 3'd2,
        S_GEN        = 3'd3,
        S_PLAY       = 3'd4,
        S_WIN        = 3'd5,
        S_LOSE       = 3'd6,
        S_CALIB_FAIL = 3'd7
    } state_t;

    // Shared timer is sized for the longest of the three intervals.
    localparam int MAX_AB = (PREP_CYCLES > PLAY_TIMEOUT) ? PREP_CYCLES : PLAY_TIMEOUT;
    localparam int MAX_T  = (MAX_AB > CALIB_TIMEOUT) ? MAX_AB : CALIB_TIMEOUT;
    localparam int TW     = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] PREP_LAST  = TW'(PREP_CYCLES - 1);
    localparam logic [TW-1:0] PLAY_LAST  = TW'((PLAY_TIMEOUT == 0) ? 0 : PLAY_TIMEOUT - 1);
    localparam logic [TW-1:0] CALIB_LAST = TW'((CALIB_TIMEOUT == 0) ? 0 : CALIB_TIMEOUT - 1);
    localparam logic [SW-1:0] SCORE_MAX  = SW'(NUM_ROUNDS);
    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);

    state_t          state, state_nxt, prev_state;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   score_nxt;
    logic [LW-1:0]   lives_nxt;
    logic            hold;

`ifdef EQM_PAUSE_EN
    // Pause only freezes the timed, event-driven states.
    assign hold    = pause && (state == S_PREP || state == S_PLAY);
    assign pausado = hold;
`else
    assign hold = 1'b0;
`endif

    // State, previous state, score and lives registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_CALIB;
            prev_state <= S_CALIB;
            score      <= '0;
            lives      <= LIVES_INIT;
        end else begin
            state      <= state_nxt;
            prev_state <= state;
            score      <= score_nxt;
            lives      <= lives_nxt;
        end
    end

    // Shared timer: restarts on every state change, frozen while paused, saturates otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (!hold && timer != {TW{1'b1}}) begin
            timer <= timer + TW'(1);
        end
    end

    // Next-state, score/lives update and Moore output decode.
    always_comb begin
        state_nxt         = state;
        score_nxt         = score;
        lives_nxt         = lives;
        gerar_nova_jogada = 1'b0;
        conta_nivel       = 1'b0;
        reset_nivel       = 1'b0;
        fade_trigger      = 1'b0;
        trava_servo       = 1'b0;
        calib_start       = 1'b0;
        game_over         = 1'b0;
        venceu            = 1'b0;
        calib_fault       = 1'b0;

        case (state)
            S_CALIB: begin
                calib_start = 1'b1;
                reset_nivel = 1'b1;
                // The end-stop wins over the watchdog when both land together.
                if (sensor_fim_curso) begin
                    state_nxt = S_SEL;
                end else if (CALIB_TIMEOUT != 0 && timer == CALIB_LAST) begin
                    state_nxt = S_CALIB_FAIL;
                end
            end
            S_CALIB_FAIL: begin
                calib_fault = 1'b1;
                if (start_game) begin
                    state_nxt = S_CALIB;
                end
            end
            S_SEL: begin
                reset_nivel = 1'b1;
                trava_servo = 1'b1;
                score_nxt   = '0;
                lives_nxt   = LIVES_INIT;
                if (start_game) begin
                    state_nxt = S_PREP;
                end
            end
            S_PREP: begin
                if (!hold && timer == PREP_LAST) begin
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                gerar_nova_jogada = 1'b1;
                state_nxt         = S_PLAY;
            end
            S_PLAY: begin
                conta_nivel  = !hold;
                // Fires once on entry; a pause keeps the state so it cannot re-fire.
                fade_trigger = (prev_state != S_PLAY);
                if (!hold) begin
                    if (ponto_evento) begin
                        if (score != SCORE_MAX) begin
                            score_nxt = score + SW'(1);
                        end
                        state_nxt = (score_nxt == SCORE_MAX) ? S_WIN : S_PREP;
                    end else if (erro_evento ||
                                 (PLAY_TIMEOUT != 0 && timer == PLAY_LAST)) begin
                        if (lives != '0) begin
                            lives_nxt = lives - LW'(1);
                        end
                        state_nxt = (lives <= LW'(1)) ? S_LOSE : S_PREP;
                    end
                end
            end
            S_WIN: begin
                game_over = 1'b1;
                venceu    = 1'b1;
                if (start_game) begin
                    state_nxt = S_SEL;
                end
            end
            S_LOSE: begin
                game_over = 1'b1;
                if (start_game) begin
                    state_nxt = S_SEL;
                end
            end
            default: begin
                state_nxt = S_CALIB;
            end
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_eqm_game_ctrl.sv
// Directed bench for eqm_game_ctrl with small timing parameters.
// Checks every clock edge against a hand-written vector table plus corner sequences.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_eqm_game_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_game = 1'b0;
    logic       ponto_evento = 1'b0;
    logic       erro_evento = 1'b0;
    logic       sensor_fim_curso = 1'b0;
    logic       gerar_nova_jogada, conta_nivel, reset_nivel, fade_trigger, trava_servo;
    logic       calib_start, game_over, venceu, calib_fault;
    logic [1:0] score, lives;
    logic [2:0] db_estado;
`ifdef EQM_PAUSE_EN
    logic       pause = 1'b0;
    logic       pausado;
`endif

    int   checks = 0;
    int   errors = 0;
    logic [2:0] prev_exp = 3'd0;
    logic       exp_paused = 1'b0;

    eqm_game_ctrl #(
        .NUM_ROUNDS(3), .LIVES(2), .PREP_CYCLES(4), .PLAY_TIMEOUT(20), .CALIB_TIMEOUT(50)
    ) dut (
        .clock(clock), .reset(reset), .start_game(start_game),
        .ponto_evento(ponto_evento), .erro_evento(erro_evento),
        .sensor_fim_curso(sensor_fim_curso),
`ifdef EQM_PAUSE_EN
        .pause(pause), .pausado(pausado),
`endif
        .gerar_nova_jogada(gerar_nova_jogada), .conta_nivel(conta_nivel),
        .reset_nivel(reset_nivel), .fade_trigger(fade_trigger), .trava_servo(trava_servo),
        .calib_start(calib_start), .game_over(game_over), .venceu(venceu),
        .calib_fault(calib_fault), .score(score), .lives(lives), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         n;
        logic       start, ponto, erro, sensor;
        logic [2:0] st;
        logic [1:0] sc, lv;
    } vec_t;

    vec_t tbl[$];

    // Expected flags {gerar, conta, reset_nivel, fade, trava, calib_start, game_over, venceu, calib_fault}.
    function automatic logic [8:0] exp_flags(input logic [2:0] st, input logic [2:0] prev);
        logic [8:0] f;
        f[8] = (st == 3'd3);
        f[7] = (st == 3'd4) && !exp_paused;
        f[6] = (st == 3'd0) || (st == 3'd1);
        f[5] = (st == 3'd4) && (prev != 3'd4);
        f[4] = (st == 3'd1);
        f[3] = (st == 3'd0);
        f[2] = (st == 3'd5) || (st == 3'd6);
        f[1] = (st == 3'd5);
        f[0] = (st == 3'd7);
        return f;
    endfunction

    task automatic check(input string name, input logic [2:0] st, input logic [1:0] sc,
                         input logic [1:0] lv);
        logic [8:0] ef, af;
        logic       bad;
        ef = exp_flags(st, prev_exp);
        af = {gerar_nova_jogada, conta_nivel, reset_nivel, fade_trigger, trava_servo,
              calib_start, game_over, venceu, calib_fault};
        bad = (db_estado !== st) || (score !== sc) || (lives !== lv) || (af !== ef);
`ifdef EQM_PAUSE_EN
        if (pausado !== (exp_paused && (st == 3'd2 || st == 3'd4))) bad = 1'b1;
`endif
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got state=%0d score=%0d lives=%0d flags=%b, want state=%0d score=%0d lives=%0d flags=%b",
                     name, db_estado, score, lives, af, st, sc, lv, ef);
        end
        prev_exp = st;
    endtask

    task automatic step(input string name, input logic s, input logic p, input logic e,
                        input logic f, input logic [2:0] st, input logic [1:0] sc,
                        input logic [1:0] lv);
        start_game = s; ponto_evento = p; erro_evento = e; sensor_fim_curso = f;
        @(posedge clock);
        #1;
        check(name, st, sc, lv);
    endtask

    // Asserted between edges so the first check proves the reset is asynchronous.
    task automatic do_reset(input string name);
        start_game = 0; ponto_evento = 0; erro_evento = 0; sensor_fim_curso = 0;
        reset = 1'b1;
        #1;
        prev_exp = 3'd0;
        check(name, 3'd0, 2'd0, 2'd2);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // From the first PREP cycle: three more PREP cycles, one GEN, then PLAY entry.
    task automatic to_play(input string name, input logic [1:0] sc, input logic [1:0] lv);
        repeat (3) step({name, "_prep"}, 0, 0, 0, 0, 3'd2, sc, lv);
        step({name, "_gen"}, 0, 0, 0, 0, 3'd3, sc, lv);
        step({name, "_play"}, 0, 0, 0, 0, 3'd4, sc, lv);
    endtask

    task automatic add(input int n, input logic s, input logic p, input logic e, input logic f,
                       input logic [2:0] st, input logic [1:0] sc, input logic [1:0] lv);
        vec_t v;
        v.n = n; v.start = s; v.ponto = p; v.erro = e; v.sensor = f;
        v.st = st; v.sc = sc; v.lv = lv;
        tbl.push_back(v);
    endtask

    initial begin
        //   n  st pt er sn  state sc lv
        add(10, 0, 0, 0, 0, 3'd0, 0, 2);   // calibrating
        add(1,  0, 0, 0, 1, 3'd1, 0, 2);   // end-stop -> SEL
        add(3,  0, 0, 0, 0, 3'd1, 0, 2);
        add(1,  1, 0, 0, 0, 3'd2, 0, 2);   // start -> PREP
        add(3,  0, 1, 1, 0, 3'd2, 0, 2);   // events ignored in PREP
        add(1,  0, 0, 0, 0, 3'd3, 0, 2);   // GEN after 4 PREP cycles
        add(1,  0, 0, 0, 0, 3'd4, 0, 2);   // PLAY, fade
        add(1,  0, 1, 0, 0, 3'd2, 1, 2);   // point 1
        add(3,  0, 0, 0, 0, 3'd2, 1, 2);
        add(1,  0, 0, 0, 0, 3'd3, 1, 2);
        add(1,  0, 0, 0, 0, 3'd4, 1, 2);
        add(1,  0, 1, 1, 0, 3'd2, 2, 2);   // point wins over miss
        add(3,  0, 0, 0, 0, 3'd2, 2, 2);
        add(1,  0, 0, 0, 0, 3'd3, 2, 2);
        add(1,  0, 0, 0, 0, 3'd4, 2, 2);
        add(1,  0, 1, 0, 0, 3'd5, 3, 2);   // third point -> WIN
        add(2,  0, 0, 0, 0, 3'd5, 3, 2);   // held
        add(1,  1, 0, 0, 0, 3'd1, 3, 2);   // start -> SEL
        add(1,  1, 0, 0, 0, 3'd2, 0, 2);   // start still high -> PREP, score cleared
        add(3,  0, 0, 0, 0, 3'd2, 0, 2);
        add(1,  0, 0, 0, 0, 3'd3, 0, 2);
        add(1,  0, 0, 0, 0, 3'd4, 0, 2);
        add(1,  0, 0, 1, 0, 3'd2, 0, 1);   // miss
        add(3,  0, 0, 0, 0, 3'd2, 0, 1);
        add(1,  0, 0, 0, 0, 3'd3, 0, 1);
        add(1,  0, 0, 0, 0, 3'd4, 0, 1);
        add(19, 0, 0, 0, 0, 3'd4, 0, 1);   // waiting in PLAY
        add(1,  0, 0, 0, 0, 3'd6, 0, 0);   // timeout on 20th cycle -> LOSE
        add(2,  0, 0, 0, 0, 3'd6, 0, 0);
        add(1,  1, 0, 0, 0, 3'd1, 0, 0);
        add(1,  0, 0, 0, 0, 3'd1, 0, 2);   // SEL restores lives

        #12;
        prev_exp = 3'd0;
        check("reset_hold", 3'd0, 2'd0, 2'd2);
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step($sformatf("row%0d", i), tbl[i].start, tbl[i].ponto, tbl[i].erro,
                     tbl[i].sensor, tbl[i].st, tbl[i].sc, tbl[i].lv);
            end
        end

        // Calibration watchdog, sticky fault, retry.
        do_reset("reset_wd");
        repeat (49) step("wd_wait", 0, 0, 0, 0, 3'd0, 0, 2);
        step("wd_fire", 0, 0, 0, 0, 3'd7, 0, 2);
        repeat (3) step("wd_sticky", 0, 0, 0, 1, 3'd7, 0, 2);
        step("wd_retry", 1, 0, 0, 0, 3'd0, 0, 2);
        step("wd_recal", 0, 0, 0, 1, 3'd1, 0, 2);

        // Sensor beats the watchdog on the last calibration cycle.
        do_reset("reset_prio");
        repeat (49) step("prio_wait", 0, 0, 0, 0, 3'd0, 0, 2);
        step("prio_sensor", 0, 0, 0, 1, 3'd1, 0, 2);

        // Asynchronous reset in PLAY with score 2.
        step("mid_start", 1, 0, 0, 0, 3'd2, 0, 2);
        to_play("mid_r1", 2'd0, 2'd2);
        step("mid_pt1", 0, 1, 0, 0, 3'd2, 1, 2);
        to_play("mid_r2", 2'd1, 2'd2);
        step("mid_pt2", 0, 1, 0, 0, 3'd2, 2, 2);
        to_play("mid_r3", 2'd2, 2'd2);
        do_reset("reset_mid");
        step("after_reset", 0, 0, 0, 0, 3'd0, 0, 2);

`ifdef EQM_PAUSE_EN
        // Pause in PLAY freezes the timer and ignores points.
        step("p_sel", 0, 0, 0, 1, 3'd1, 0, 2);
        step("p_start", 1, 0, 0, 0, 3'd2, 0, 2);
        to_play("p_r", 2'd0, 2'd2);
        pause = 1'b1;
        exp_paused = 1'b1;
        repeat (10) step("p_hold", 0, 1, 0, 0, 3'd4, 0, 2);
        pause = 1'b0;
        exp_paused = 1'b0;
        repeat (19) step("p_resume", 0, 0, 0, 0, 3'd4, 0, 2);
        step("p_timeout", 0, 0, 0, 0, 3'd2, 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
